// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR coefficient controller.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } ctrl_state_t;

    // Input-valid to output-valid depth of the FIR datapath.
    localparam int FIR_LATENCY = 24;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register file. Host writes land in the shadow
// bank; a swap strobe copies every shadow word into the active bank at once.
module fir_coeff_bank #(
    parameter int DW     = 18,
    parameter int N_UNIQ = 9,
    parameter int AW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 swap,
    output logic [N_UNIQ*DW-1:0] coeff_active
);

    logic [DW-1:0] shadow [N_UNIQ];
    logic [DW-1:0] active [N_UNIQ];

    // Shadow takes host writes; active reloads from shadow in one shot on swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_UNIQ; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_UNIQ; k++) begin
                if (wr_en && (wr_addr == AW'(k))) shadow[k] <= wr_data;
                if (swap) active[k] <= shadow[k];
            end
        end
    end

    // Flatten the active bank, coefficient k at [k*DW +: DW].
    always_comb begin
        coeff_active = '0;
        for (int k = 0; k < N_UNIQ; k++) begin
            coeff_active[k*DW +: DW] = active[k];
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Runtime coefficient controller for the symmetric FIR. Commits stall the
// sample stream until every sample in the FIR pipeline has come out, then
// swap the coefficient banks in a single cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | streaming; samples and coefficient writes accepted
//   ST_DRAIN | commit pending; input blocked until the FIR pipeline empties
//   ST_SWAP  | one cycle; active bank loads from shadow
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DW      = 18,
    parameter int N_UNIQ  = 9,
    parameter int LATENCY = FIR_LATENCY,
    parameter int AW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wr_valid,
    output logic                 cfg_wr_ready,
    input  logic [AW-1:0]        cfg_wr_addr,
    input  logic [DW-1:0]        cfg_wr_data,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic                 cfg_err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic                 fir_i_valid,
    output logic [DW-1:0]        fir_i_in,
    input  logic                 fir_o_valid,
    output logic [N_UNIQ*DW-1:0] coeff_active
);

    localparam int IW = clog2(LATENCY + 1);

    ctrl_state_t   state, state_nxt;
    logic [IW-1:0] inflight;
    logic          s_accept;
    logic          wr_accept;
    logic          addr_ok;
    logic          bank_swap;

    assign s_accept  = s_valid && s_ready;
    assign wr_accept = cfg_wr_valid && cfg_wr_ready;
    assign addr_ok   = 32'(cfg_wr_addr) < N_UNIQ;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; a commit seen outside RUN is dropped.
    always_comb begin
        state_nxt    = state;
        bank_swap    = 1'b0;
        s_ready      = 1'b0;
        cfg_wr_ready = 1'b0;
        unique case (state)
            ST_RUN: begin
                s_ready      = 1'b1;
                cfg_wr_ready = 1'b1;
                if (cfg_commit) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((inflight == '0) && !fir_i_valid) state_nxt = ST_SWAP;
            end
            ST_SWAP: begin
                bank_swap = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        cfg_busy = (state != ST_RUN) && !reset;
    end

    // One-cycle sample register in front of the FIR; data holds between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            fir_i_valid <= 1'b0;
            fir_i_in    <= '0;
        end else begin
            fir_i_valid <= s_accept;
            if (s_accept) fir_i_in <= s_data;
        end
    end

    // Samples inside the FIR arithmetic: up on issue, down on output.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else if (fir_i_valid && !fir_o_valid) begin
            if (inflight < IW'(LATENCY)) inflight <= inflight + IW'(1);
        end else if (!fir_i_valid && fir_o_valid) begin
            if (inflight != '0) inflight <= inflight - IW'(1);
        end
    end

    // Sticky flag for writes aimed past the last unique coefficient.
    always_ff @(posedge clk) begin
        if (reset)                     cfg_err <= 1'b0;
        else if (wr_accept && !addr_ok) cfg_err <= 1'b1;
    end

    // An output with nothing in flight means the FIR and this counter disagree.
    underflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(fir_o_valid && !fir_i_valid && (inflight == '0)));

    fir_coeff_bank #(
        .DW     (DW),
        .N_UNIQ (N_UNIQ),
        .AW     (AW)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_accept && addr_ok),
        .wr_addr      (cfg_wr_addr),
        .wr_data      (cfg_wr_data),
        .swap         (bank_swap),
        .coeff_active (coeff_active)
    );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: directed scenario sequence with random data,
// checked against array models of the two coefficient banks.
module tb_fir_coeff_ctrl;

    localparam int DW      = 18;
    localparam int N_UNIQ  = 9;
    localparam int LATENCY = 24;
    localparam int AW      = 4;
    localparam int CW      = N_UNIQ * DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_wr_valid;
    logic              cfg_wr_ready;
    logic [AW-1:0]     cfg_wr_addr;
    logic [DW-1:0]     cfg_wr_data;
    logic              cfg_commit;
    logic              cfg_busy;
    logic              cfg_err;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              fir_i_valid;
    logic [DW-1:0]     fir_i_in;
    logic              fir_o_valid;
    logic [CW-1:0]     coeff_active;
    logic [LATENCY-1:0] fir_pipe;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] shadow_m [N_UNIQ];
    logic [DW-1:0] active_m [N_UNIQ];
    logic          err_m;

    fir_coeff_ctrl #(
        .DW(DW), .N_UNIQ(N_UNIQ), .LATENCY(LATENCY), .AW(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_commit   (cfg_commit),
        .cfg_busy     (cfg_busy),
        .cfg_err      (cfg_err),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .fir_i_valid  (fir_i_valid),
        .fir_i_in     (fir_i_in),
        .fir_o_valid  (fir_o_valid),
        .coeff_active (coeff_active)
    );

    always #5 clk = ~clk;

    // Stand-in for the FIR: every issued sample comes back LATENCY cycles later.
    always @(posedge clk) begin
        if (reset) fir_pipe <= '0;
        else       fir_pipe <= {fir_pipe[LATENCY-2:0], fir_i_valid};
    end
    assign fir_o_valid = fir_pipe[LATENCY-1];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_coeffs();
        logic [CW-1:0] v;
        v = '0;
        for (int k = 0; k < N_UNIQ; k++) v[k*DW +: DW] = active_m[k];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_UNIQ; k++) begin
            shadow_m[k] = '0;
            active_m[k] = '0;
        end
        err_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cfg_write(input int addr, input int data);
        check("wr_ready_run", cfg_wr_ready, 1'b1);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = AW'(addr);
        cfg_wr_data  = DW'(data);
        tick();
        cfg_wr_valid = 1'b0;
        if (addr < N_UNIQ) shadow_m[addr] = DW'(data);
        else               err_m = 1'b1;
    endtask

    // Called just after the commit edge; follows the controller until it is idle.
    task automatic wait_idle(input int bound, output int busy_cnt, output int zero_cyc,
                             output int fall_cyc);
        busy_cnt = 0;
        zero_cyc = -1;
        fall_cyc = -1;
        for (int n = 0; n < bound && fall_cyc < 0; n++) begin
            if (cfg_busy) begin
                busy_cnt++;
                if (zero_cyc < 0 && dut.inflight == 0) zero_cyc = cyc;
                check("busy_s_ready", s_ready, 1'b0);
                check("busy_wr_ready", cfg_wr_ready, 1'b0);
                check("busy_coeff_hold", coeff_active, model_coeffs());
                tick();
            end else begin
                fall_cyc = cyc;
            end
        end
        if (fall_cyc < 0) check("busy_timeout", cfg_busy, 1'b0);
        else for (int k = 0; k < N_UNIQ; k++) active_m[k] = shadow_m[k];
    endtask

    initial begin
        int             vals [N_UNIQ];
        logic [DW-1:0]  last_acc;
        logic           exp_v;
        int             bc, zc, fc, e_commit;

        reset = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_commit = 1'b0; s_valid = 1'b0; s_data = '0;
        model_clear();

        // Reset
        tick();
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check("rst_fir_i_valid", fir_i_valid, 1'b0);
        check("rst_fir_i_in", fir_i_in, '0);
        check("rst_coeff", coeff_active, '0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_inflight", dut.inflight, '0);
        check("rst_wr_ready", cfg_wr_ready, 1'b1);

        // Continuous streaming
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_data = DW'($urandom);
            tick();
            check("stream_s_ready", s_ready, 1'b1);
            check("stream_valid", fir_i_valid, 1'b1);
            check("stream_data", fir_i_in, s_data);
        end
        last_acc = s_data;

        // Gappy streaming
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            exp_v   = s_valid;
            if (s_valid) last_acc = s_data;
            tick();
            check("gap_valid", fir_i_valid, exp_v);
            check("gap_data", fir_i_in, last_acc);
        end
        s_valid = 1'b0;
        repeat (LATENCY + 6) tick();
        check("drained_inflight", dut.inflight, '0);
        check("hold_data", fir_i_in, last_acc);

        // Full bank write and commit with the FIR idle
        vals[0] = 88; vals[1] = 0; vals[2] = -97; vals[N_UNIQ-1] = -504;
        for (int k = 3; k < N_UNIQ - 1; k++) vals[k] = int'($urandom_range(0, 4000)) - 2000;
        for (int k = 0; k < N_UNIQ; k++) cfg_write(k, vals[k]);
        check("pre_commit_coeff", coeff_active, '0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        wait_idle(10, bc, zc, fc);
        check("idle_commit_busy_cycles", 32'(bc), 32'd2);
        check("idle_commit_coeff", coeff_active, model_coeffs());
        check("idle_commit_s_ready", s_ready, 1'b1);

        // Drain with 5 samples in flight; commit on the 5th sample
        cfg_write(5, int'($urandom_range(0, 60000)) - 30000);
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = DW'($urandom);
            if (i == 4) cfg_commit = 1'b1;
            tick();
        end
        last_acc = s_data;
        e_commit = cyc;
        cfg_commit   = 1'b0;
        s_data       = DW'($urandom);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = '0;
        cfg_wr_data  = DW'(777);
        wait_idle(LATENCY + 20, bc, zc, fc);
        s_valid      = 1'b0;
        cfg_wr_valid = 1'b0;
        check("drain_busy_cycles", 32'(bc), 32'(LATENCY + 3));
        check("drain_fall_cycle", 32'(fc), 32'(e_commit + LATENCY + 3));
        check("drain_zero_to_run", 32'(fc - zc), 32'd2);
        check("drain_coeff", coeff_active, model_coeffs());
        check("drain_last_sample", fir_i_in, last_acc);
        check("drain_err_clear", cfg_err, err_m);

        // Out-of-range writes
        cfg_write(9, 123);
        check("err_set", cfg_err, 1'b1);
        cfg_write(int'($urandom_range(10, 15)), int'($urandom_range(0, 1000)));
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        wait_idle(10, bc, zc, fc);
        check("err_coeff_unchanged", coeff_active, model_coeffs());
        repeat (5) tick();
        check("err_sticky", cfg_err, err_m);

        // Write and commit together; commits held through DRAIN and SWAP
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = AW'(3);
        cfg_wr_data  = DW'($urandom);
        cfg_commit   = 1'b1;
        check("wc_wr_ready", cfg_wr_ready, 1'b1);
        tick();
        shadow_m[3]  = cfg_wr_data;
        cfg_wr_valid = 1'b0;
        wait_idle(10, bc, zc, fc);
        cfg_commit = 1'b0;
        check("wc_busy_cycles", 32'(bc), 32'd2);
        check("wc_coeff", coeff_active, model_coeffs());
        repeat (4) tick();
        check("wc_no_second_swap", cfg_busy, 1'b0);

        // Reset in the middle of a drain
        cfg_write(1, int'($urandom_range(1, 5000)));
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = DW'($urandom);
            if (i == 2) cfg_commit = 1'b1;
            tick();
        end
        cfg_commit = 1'b0;
        s_valid    = 1'b0;
        tick();
        check("mid_busy", cfg_busy, 1'b1);
        check("mid_inflight", dut.inflight, 5'd3);
        reset = 1'b1;
        tick();
        model_clear();
        check("rst_mid_busy", cfg_busy, 1'b0);
        check("rst_mid_s_ready", s_ready, 1'b1);
        check("rst_mid_coeff", coeff_active, model_coeffs());
        check("rst_mid_inflight", dut.inflight, '0);
        check("rst_mid_err", cfg_err, err_m);
        reset = 1'b0;
        repeat (3) tick();
        check("rst_mid_abandoned", cfg_busy, 1'b0);
        check("rst_mid_coeff_after", coeff_active, model_coeffs());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
